// File: rtl/seanetnackgenerator_timer_queue.sv
`default_nettype none
// ============================================================================
// Module   : seanetnackgenerator_timer_queue
// Function : FIFO of timer records released in order once a shared timeout
//            elapses; expired heads are reloaded (cnt+1) or dropped.
// Revision : 1.0 - initial release
// ============================================================================
module seanetnackgenerator_timer_queue #(
  parameter int          DEPTH         = 16,
  parameter int          TICK_DIV      = 250,
  parameter int          MAX_RLD       = 3,
  parameter logic [31:0] NOW_TICK_INIT = 32'd0
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic [511:0] i_timer_wrreq,
  input  logic         i_timer_wrreq_vld,
  output logic         o_timer_wrreq_rdy,
  output logic [15:0]  o_exp_tmg_sn,
  output logic [15:0]  o_exp_tmg_cnt,
  output logic [31:0]  o_exp_tmg_chksum,
  output logic [447:0] o_exp_tmg_gen_req,
  output logic         o_exp_tmg_valid,
  input  logic         i_exp_tmg_ready,
  output logic         o_drop_vld,
  output logic [15:0]  o_drop_sn,
  input  logic [31:0]  i_cfg_reg0,
  output logic [31:0]  o_sta_reg0,
  output logic [31:0]  o_sta_reg1,
  output logic [31:0]  o_sta_reg2,
  output logic [31:0]  o_sta_reg3
);
  localparam int              AW        = $clog2(DEPTH);
  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   C_PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [AW:0]     C_DEPTH   = (AW + 1)'(DEPTH);
  localparam logic [15:0]     C_MAX_RLD = 16'(MAX_RLD);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_DROP} state_t;
  state_t r_state, w_state_nxt;

  logic [511:0]  r_mem [DEPTH];
  logic [31:0]   r_ts  [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic [PW-1:0] r_pre;
  logic [31:0]   r_now;
  logic          r_live;
  logic [15:0]   r_in_cnt, r_exp_cnt, r_drop_cnt;
  logic          r_err;

  logic          w_full, w_empty, w_wr, w_pop, w_emit, w_drop, w_expired, w_clr;
  logic [511:0]  w_head;
  logic [31:0]   w_age, w_tmo;
  logic [15:0]   w_head_cnt;
  logic          w_unused_cfg;

  assign w_full       = (r_count == C_DEPTH);
  assign w_empty      = (r_count == '0);
  assign w_clr        = i_cfg_reg0[0];
  assign w_unused_cfg = ^i_cfg_reg0[15:1];
  assign o_timer_wrreq_rdy = r_live & ~w_full;
  assign w_wr         = i_timer_wrreq_vld & o_timer_wrreq_rdy;
  assign w_emit       = (r_state == S_EMIT);
  assign w_drop       = (r_state == S_DROP);
  assign w_pop        = (w_emit & i_exp_tmg_ready) | w_drop;

  assign w_head     = r_mem[r_rp];
  assign w_head_cnt = w_head[511:496];
  assign w_tmo      = (i_cfg_reg0[31:16] == 16'd0) ? 32'd1 : {16'd0, i_cfg_reg0[31:16]};
  // Modular subtraction keeps the age correct across now_tick wrap.
  assign w_age      = r_now - r_ts[r_rp];
  assign w_expired  = ~w_empty & (w_age >= w_tmo);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pre  <= '0;
      r_now  <= NOW_TICK_INIT;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (r_pre == C_PRE_MAX) begin
        r_pre <= '0;
        r_now <= r_now + 32'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= i_timer_wrreq;
      r_ts[r_wp]  <= r_now;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!w_empty) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_expired) w_state_nxt = (w_head_cnt >= C_MAX_RLD) ? S_DROP : S_EMIT;
      end
      S_EMIT: begin
        if (i_exp_tmg_ready)
          w_state_nxt = ((r_count == 1) && !w_wr) ? S_IDLE : S_WAIT;
      end
      S_DROP:  w_state_nxt = ((r_count == 1) && !w_wr) ? S_IDLE : S_WAIT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_in_cnt   <= '0;
      r_exp_cnt  <= '0;
      r_drop_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_clr) begin
      r_in_cnt   <= '0;
      r_exp_cnt  <= '0;
      r_drop_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_wr)                      r_in_cnt   <= r_in_cnt + 16'd1;
      if (w_emit && i_exp_tmg_ready) r_exp_cnt  <= r_exp_cnt + 16'd1;
      if (w_drop)                    r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_wr && w_full)            r_err      <= 1'b1;
    end
  end

  // Output fields are forced to zero outside their valid state.
  assign o_exp_tmg_valid   = w_emit;
  assign o_exp_tmg_sn      = w_emit ? w_head[495:480] : 16'd0;
  assign o_exp_tmg_cnt     = !w_emit ? 16'd0 :
                             (w_head_cnt == 16'hFFFF) ? 16'hFFFF : w_head_cnt + 16'd1;
  assign o_exp_tmg_chksum  = w_emit ? w_head[479:448] : 32'd0;
  assign o_exp_tmg_gen_req = w_emit ? w_head[447:0] : 448'd0;
  assign o_drop_vld        = w_drop;
  assign o_drop_sn         = w_drop ? w_head[495:480] : 16'd0;

  assign o_sta_reg0 = {r_in_cnt, r_exp_cnt};
  assign o_sta_reg1 = {r_drop_cnt, 11'd0, 5'(r_count)};
  assign o_sta_reg2 = r_live ? {28'd0, r_err, w_full, w_empty, w_emit} : 32'd0;
  assign o_sta_reg3 = r_now;
endmodule
`default_nettype wire

// File: tb/tb_seanetnackgenerator_timer_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_seanetnackgenerator_timer_queue
// Function : scoreboard bench for the timer queue (TICK_DIV=2, start near wrap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seanetnackgenerator_timer_queue;
  localparam logic [31:0] C_NOW_INIT = 32'hFFFF_FFF0;

  logic         clk, rst_n;
  logic [511:0] r_wrreq;
  logic         r_vld, r_ready;
  logic [31:0]  r_cfg;
  logic         w_rdy, w_valid, w_drop_vld;
  logic [15:0]  w_sn, w_cnt, w_drop_sn;
  logic [31:0]  w_ck, w_sta0, w_sta1, w_sta2, w_sta3;
  logic [447:0] w_gen;

  seanetnackgenerator_timer_queue #(
    .DEPTH(16), .TICK_DIV(2), .MAX_RLD(3), .NOW_TICK_INIT(C_NOW_INIT)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .i_timer_wrreq(r_wrreq), .i_timer_wrreq_vld(r_vld), .o_timer_wrreq_rdy(w_rdy),
    .o_exp_tmg_sn(w_sn), .o_exp_tmg_cnt(w_cnt), .o_exp_tmg_chksum(w_ck),
    .o_exp_tmg_gen_req(w_gen), .o_exp_tmg_valid(w_valid), .i_exp_tmg_ready(r_ready),
    .o_drop_vld(w_drop_vld), .o_drop_sn(w_drop_sn), .i_cfg_reg0(r_cfg),
    .o_sta_reg0(w_sta0), .o_sta_reg1(w_sta1), .o_sta_reg2(w_sta2), .o_sta_reg3(w_sta3)
  );

  typedef struct packed {
    logic        is_drop;
    logic        tchk;
    logic [31:0] tick;
    logic [15:0] cnt;
    logic [15:0] sn;
    logic [31:0] ck;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   hs_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Called in the low clock phase; returns at posedge+1 after acceptance.
  task automatic wr(input logic [15:0] cnt, input logic [15:0] sn, input logic [31:0] ck,
                    input logic is_drop, input logic tchk, input logic [31:0] tick);
    int   t = 0;
    exp_t e;
    r_vld   = 1'b1;
    r_wrreq = {cnt, sn, ck, {14{ck}}};
    while (!w_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!w_rdy) begin
      timeout("wr_accept");
      r_vld = 1'b0;
      return;
    end
    e.is_drop = is_drop;
    e.tchk    = tchk;
    e.tick    = tick;
    e.cnt     = cnt + 16'd1;
    e.sn      = sn;
    e.ck      = ck;
    sb.push_back(e);
    @(posedge clk);
    #1 r_vld = 1'b0;
  endtask

  task automatic wait_tick(input logic [31:0] t);
    int n = 0;
    @(negedge clk);
    while (w_sta3 != t && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (w_sta3 != t) timeout("wait_tick");
  endtask

  task automatic wait_drain(input string nm, input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) timeout(nm);
    @(negedge clk);
  endtask

  task automatic stat_clear();
    @(posedge clk);
    #1 r_cfg[0] = 1'b1;
    @(posedge clk);
    #1 r_cfg[0] = 1'b0;
  endtask

  // Monitor: pops expected records on every emit handshake or drop pulse.
  logic         m_fresh = 1'b1;
  logic         m_hold = 1'b0;
  logic         m_prev_drop = 1'b0;
  logic [511:0] m_held;
  exp_t         m_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_fresh = 1'b1;
        m_hold = 1'b0;
        m_prev_drop = 1'b0;
      end else begin
        if (w_drop_vld) begin
          chk("drop_one_cycle", m_prev_drop, 1'b0);
          if (sb.size() == 0) timeout("drop_unexpected");
          else begin
            m_e = sb.pop_front();
            chk("drop_kind", m_e.is_drop, 1'b1);
            chk("drop_sn", w_drop_sn, m_e.sn);
          end
        end
        m_prev_drop = w_drop_vld;
        if (w_valid) begin
          if (m_hold) chk("stall_stable", {w_cnt, w_sn, w_ck, w_gen}, m_held);
          m_held = {w_cnt, w_sn, w_ck, w_gen};
          if (sb.size() == 0) timeout("emit_unexpected");
          else begin
            if (m_fresh && sb[0].tchk) chk("rise_tick", w_sta3, sb[0].tick);
            m_fresh = 1'b0;
            if (r_ready) begin
              m_e = sb.pop_front();
              chk("emit_kind", m_e.is_drop, 1'b0);
              chk("emit_fields", {w_cnt, w_sn, w_ck, w_gen},
                  {m_e.cnt, m_e.sn, m_e.ck, {14{m_e.ck}}});
              hs_cnt++;
              m_fresh = 1'b1;
            end
          end
          m_hold = !r_ready;
        end else begin
          m_hold = 1'b0;
        end
      end
    end
  end

  initial begin
    int hs0;
    logic [31:0] t0;
    rst_n = 1'b0; r_vld = 1'b0; r_wrreq = '0; r_ready = 1'b1; r_cfg = 32'h0004_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", w_rdy, 1'b0);
    chk("reset_valid", w_valid, 1'b0);
    chk("reset_sta2", w_sta2, 32'd0);
    chk("reset_sta3", w_sta3, C_NOW_INIT);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rdy_after_release", w_rdy, 1'b1);

    // Record written at now_tick FFFF_FFFE expires at 2 after the wrap.
    wait_tick(32'hFFFF_FFFE);
    wr(16'd0, 16'h0A0A, 32'h1234_5678, 1'b0, 1'b1, 32'd2);
    wait_drain("wrap_drain", 100);

    hs0 = hs_cnt;
    wait_tick(32'd10);
    wr(16'd0, 16'h0011, 32'hCAFE_0011, 1'b0, 1'b1, 32'd14);
    wait_drain("basic_drain", 100);
    chk("single_handshake", hs_cnt, hs0 + 1);

    // Timeout field 0 behaves as one tick.
    r_cfg[31:16] = 16'd0;
    wait_tick(32'd20);
    wr(16'd1, 16'h0020, 32'h0000_0020, 1'b0, 1'b1, 32'd21);
    wait_drain("tmo0_drain", 100);
    r_cfg[31:16] = 16'd4;

    stat_clear();
    @(negedge clk);
    wr(16'd3, 16'hBEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
    wr(16'd2, 16'h2222, 32'h2222_2222, 1'b0, 1'b0, 32'd0);
    wr(16'hFFFF, 16'h3333, 32'h3333_3333, 1'b1, 1'b0, 32'd0);
    wait_drain("drop_drain", 200);
    chk("drop_cnt", w_sta1[31:16], 16'd2);
    chk("exp_cnt", w_sta0[15:0], 16'd1);
    chk("in_cnt", w_sta0[31:16], 16'd3);

    // Fill while stalled, hold a 17th write, age 100 ticks, then release.
    stat_clear();
    r_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++)
      wr(16'd0, 16'h0100 + 16'(i), 32'h0101_0101 * i, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("full_rdy", w_rdy, 1'b0);
    chk("full_occ", w_sta1[4:0], 5'd16);
    r_vld = 1'b1;
    r_wrreq = {512{1'b1}};
    repeat (10) @(negedge clk);
    chk("hold_occ", w_sta1[4:0], 5'd16);
    chk("hold_err", w_sta2[3], 1'b0);
    chk("hold_in_cnt", w_sta0[31:16], 16'd16);
    @(posedge clk);
    #1 r_vld = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("stall_sta2", w_sta2[3:0], 4'b0101);
    hs0 = hs_cnt;
    @(posedge clk);
    #1 r_ready = 1'b1;
    wait_drain("b2b_drain", 60);
    chk("b2b_count", hs_cnt, hs0 + 16);
    chk("b2b_occ", w_sta1[4:0], 5'd0);
    chk("b2b_exp_cnt", w_sta0[15:0], 16'd16);

    // Reset while a record is being presented.
    r_ready = 1'b0;
    @(negedge clk);
    wr(16'd0, 16'h7777, 32'h7777_7777, 1'b0, 1'b0, 32'd0);
    begin
      int n = 0;
      while (!w_valid && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (!w_valid) timeout("emit_before_reset");
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", w_valid, 1'b0);
    chk("rst_rdy", w_rdy, 1'b0);
    chk("rst_occ", w_sta1[4:0], 5'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 r_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_rdy", w_rdy, 1'b1);
    chk("post_rst_valid", w_valid, 1'b0);
    chk("post_rst_occ", w_sta1[4:0], 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
